// File: rtl/risc_selftest_ctrl.sv
// Self-test sequencer: loads each test program into the CPU memory, resets the CPU,
// then lets it run and checks that it halts exactly one clock after its expected count.
// Ports: clk/rst (async active-low), start/abort control; test_idx, exp_clocks and prog_len
// form the test-descriptor lookup. rom_addr/rom_data read the program ROM.
// ld_* is the CPU memory write port. cpu_rst/cpu_clk_en/cpu_halt connect the CPU under test.
// busy/done/pass and fail_* report status.
module risc_selftest_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5,
    parameter int NUM_TESTS    = 4,
    parameter int TIDX_W       = 4,
    parameter int CNT_W        = 12,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [TIDX_W-1:0] test_idx,
    input  logic [CNT_W-1:0]  exp_clocks,
    input  logic [ADDR_W:0]   prog_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ld_we,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              cpu_rst,
    output logic              cpu_clk_en,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [TIDX_W-1:0] fail_test,
    output logic [CNT_W:0]    fail_cnt,
    output logic [1:0]        fail_code,
    output logic [TIDX_W:0]   fail_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RST_A, S_RST_B, S_RUN, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TIDX_W-1:0]   test_idx_q;
    // One bit wider than the memory address so a full-memory load never wraps.
    logic [ADDR_W:0]     addr_q;
    logic [CNT_W:0]      cnt_q;
    logic [TIDX_W-1:0]   fail_test_q;
    logic [CNT_W:0]      fail_cnt_q;
    logic [1:0]          fail_code_q;
    logic [TIDX_W:0]     fail_count_q;

    logic [ADDR_W:0]     addr_inc;
    logic                load_done;
    logic [CNT_W:0]      exp_p1;
    logic                early_halt;
    logic                at_limit;
    logic                run_fail;
    logic                run_pass;
    logic                last_test;
    logic                idle_or_done;

    assign addr_inc     = addr_q + 1'b1;
    // A zero-length program spends a single LOAD cycle with no writes.
    assign load_done    = (prog_len == '0) || (addr_inc >= prog_len);
    assign exp_p1       = {1'b0, exp_clocks} + 1'b1;
    // All RUN checks use the count before this cycle's increment.
    assign early_halt   = cpu_halt && (cnt_q <= {1'b0, exp_clocks});
    assign at_limit     = (cnt_q == exp_p1);
    assign run_fail     = (state_q == S_RUN) && (early_halt || (at_limit && !cpu_halt));
    assign run_pass     = (state_q == S_RUN) && at_limit && cpu_halt;
    assign last_test    = (test_idx_q == TIDX_W'(NUM_TESTS - 1));
    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, including a simultaneous start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (load_done) state_d = S_RST_A;
            S_RST_A: state_d = S_RST_B;
            S_RST_B: state_d = S_RUN;
            S_RUN: begin
                if (run_fail) begin
                    state_d = (STOP_ON_FAIL != 0) ? S_DONE : S_NEXT;
                end else if (run_pass) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:  state_d = last_test ? S_DONE : S_LOAD;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_idx_q   <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            fail_test_q  <= '0;
            fail_cnt_q   <= '0;
            fail_code_q  <= '0;
            fail_count_q <= '0;
        end else if (abort) begin
            // The failure record survives an abort; the sequencing position does not.
            test_idx_q <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (idle_or_done && start) begin
                test_idx_q   <= '0;
                addr_q       <= '0;
                fail_test_q  <= '0;
                fail_cnt_q   <= '0;
                fail_code_q  <= '0;
                fail_count_q <= '0;
            end
            if (state_q == S_LOAD) begin
                addr_q <= load_done ? '0 : addr_inc;
            end
            if (state_q == S_RST_B) begin
                cnt_q <= '0;
            end
            if (state_q == S_RUN) begin
                cnt_q <= cnt_q + 1'b1;
                if (run_fail) begin
                    if (fail_count_q != '1) begin
                        fail_count_q <= fail_count_q + 1'b1;
                    end
                    if (fail_count_q == '0) begin
                        fail_test_q <= test_idx_q;
                        fail_cnt_q  <= cnt_q;
                        fail_code_q <= early_halt ? 2'b01 : 2'b10;
                    end
                end
            end
            if ((state_q == S_NEXT) && !last_test) begin
                test_idx_q <= test_idx_q + 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        ld_we      = (state_q == S_LOAD) && (addr_q < prog_len);
        ld_data    = (state_q == S_LOAD) ? rom_data : '0;
        cpu_clk_en = (state_q == S_RST_A) || (state_q == S_RST_B) || (state_q == S_RUN);
        cpu_rst    = !((state_q == S_RST_B) || (state_q == S_RUN));
        busy       = !idle_or_done;
        done       = (state_q == S_DONE);
        pass       = (state_q == S_DONE) && (fail_count_q == '0);
    end

    assign test_idx   = test_idx_q;
    assign rom_addr   = addr_q[ADDR_W-1:0];
    assign ld_addr    = addr_q[ADDR_W-1:0];
    assign fail_test  = fail_test_q;
    assign fail_cnt   = fail_cnt_q;
    assign fail_code  = fail_code_q;
    assign fail_count = fail_count_q;

endmodule

// File: doc/risc_selftest_ctrl.md
RISC_SELFTEST_CTRL -- requirements
Module: risc_selftest_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, CPU memory word width.
REQ-002 Parameter ADDR_W, default 5, CPU memory address width.
REQ-003 Parameter NUM_TESTS, default 4, test programs per run (1..2^TIDX_W).
REQ-004 Parameter TIDX_W, default 4, test index width.
REQ-005 Parameter CNT_W, default 12, CPU clock counter width.
REQ-006 Parameter STOP_ON_FAIL, default 1: 1 = end run at first failure; 0 = run all tests.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  begin run; sampled in IDLE and DONE only.
REQ-010 abort  input  1  synchronous abort to IDLE.
REQ-011 test_idx  output  TIDX_W  current test number, selects descriptor and program ROM.
REQ-012 exp_clocks  input  CNT_W  expected halt-free CPU clocks for test_idx.
REQ-013 prog_len  input  ADDR_W+1  words to load for test_idx (0..2^ADDR_W).
REQ-014 rom_addr  output  ADDR_W  program ROM word address.
REQ-015 rom_data  input  DATA_W  combinational ROM word for (test_idx, rom_addr).
REQ-016 ld_we / ld_addr / ld_data  output  1 / ADDR_W / DATA_W  CPU memory write port.
REQ-017 cpu_rst  output  1  active-high CPU reset.
REQ-018 cpu_clk_en  output  1  CPU advances one clock per cycle when high.
REQ-019 cpu_halt  input  1  CPU halt flag.
REQ-020 busy, done, pass  output  1 each  status.
REQ-021 fail_test / fail_cnt / fail_code / fail_count  output  TIDX_W / CNT_W+1 / 2 / TIDX_W+1  first-failure record and failure total.

Function
REQ-022 FSM states IDLE, LOAD, RST_A, RST_B, RUN, NEXT, DONE.
REQ-023 IDLE/DONE + start: clear test_idx, fail_* and pass; go LOAD; busy=1 from the next cycle.
REQ-024 LOAD: one word per cycle, addr 0..prog_len-1; ld_we=1, ld_addr=rom_addr=addr, ld_data=rom_data.
REQ-025 LOAD with prog_len=0 goes directly to RST_A; prog_len=2^ADDR_W loads every address without counter wrap.
REQ-026 RST_A is one cycle: cpu_rst=1, cpu_clk_en=1.
REQ-027 RST_B is one cycle: cpu_rst=0, cpu_clk_en=1.
REQ-028 RUN: cpu_rst=0, cpu_clk_en=1; cnt (CNT_W+1 bits) starts at 0 and increments every RUN cycle.
REQ-029 RUN evaluation at each edge, using the pre-increment cnt:
- cpu_halt=1 with cnt<=exp_clocks: fail, code 01 (early halt).
- cnt==exp_clocks+1 with cpu_halt=1: test passes, go NEXT.
- cnt==exp_clocks+1 with cpu_halt=0: fail, code 10 (no halt).
REQ-030 On any failure:
- fail_count increments, saturating.
- First failure only: record fail_test=test_idx and fail_cnt=cnt.
- STOP_ON_FAIL=1: go DONE. STOP_ON_FAIL=0: go NEXT.
REQ-031 NEXT:
- test_idx==NUM_TESTS-1: go DONE.
- Otherwise: test_idx+1, go LOAD.
REQ-032 DONE: done=1, busy=0, pass=(fail_count==0); results held until the next start.
REQ-033 abort in any non-IDLE state: go IDLE next cycle, cpu_rst=1, ld_we=0; fail_* retained; done=0.
REQ-034 start and abort in the same cycle: abort wins.
REQ-035 Outside LOAD: ld_we=0. Outside RST_A..RUN: cpu_clk_en=0, cpu_rst=1.

Reset
REQ-036 rst low forces IDLE immediately, from any state.
REQ-037 While rst is low:
- cpu_rst=1; cpu_clk_en=0; ld_we=0.
- busy=0; done=0; pass=0.
- test_idx=0; rom_addr=0; ld_addr=0; ld_data=0.
- fail_test=0; fail_cnt=0; fail_code=0; fail_count=0.
REQ-038 rst deasserted mid-run: no resume; a new start is required.

Verification
REQ-039 NUM_TESTS=1; HLT program; exp_clocks=2; CPU model halts after the 3rd RUN clock -> done=1, pass=1, fail_count=0.
REQ-040 JMP program (11-clock halt); exp_clocks=10; model halts after the 5th RUN clock -> pass=0, fail_code=01, fail_cnt=5, fail_test=0.
REQ-041 exp_clocks=10; model never halts -> fail_code=10, fail_cnt=11, done one cycle later.
REQ-042 NUM_TESTS=3, STOP_ON_FAIL=0; test 1 fails, tests 0 and 2 pass -> fail_count=1, fail_test=1, test_idx reaches 2, pass=0.
REQ-043 prog_len=32, ADDR_W=5 -> exactly 32 ld_we pulses at addr 0..31.
REQ-044 Disruption cases -> each returns to IDLE outputs per REQ-037:
- rst low mid-LOAD.
- abort mid-RUN.
- start+abort together in DONE.
